// File: rtl/apb_regbank_slave_pkg.sv
// Shared types and constants for the APB register-bank completer.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 8;
    localparam int unsigned WAIT_W          = 4;
    localparam int unsigned PROT_CNT_W      = 8;
    // WAIT_CFG and ID sit at the top of the bank, counted back from NUM_REGS
    localparam int unsigned WAIT_CFG_OFFSET = 2;
    localparam int unsigned ID_OFFSET       = 1;

    localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

endpackage

// File: rtl/apb_regbank_slave_wait_ctr.sv
// Loadable down-counter that paces wait states; zero_c flags the last wait.
module apb_wait_ctr
    import apb_pkg::*;
(
    input  logic              apb_clk,
    input  logic              sys_reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero_c
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/apb_regbank_slave.sv
// APB completer with a word-indexed register bank, programmable wait states and error response.
// Define APB_PROT_ERR_CNT_EN to enable the saturating protocol-violation counter.
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter int unsigned       NUM_REGS     = 32,
    parameter logic [DATA_W-1:0] ID_VALUE     = ID_VALUE_DEFAULT,
    parameter int unsigned       WAIT_DEFAULT = 0
) (
    input  logic                  apb_clk,
    input  logic                  sys_reset,
    input  logic                  apb_selx,
    input  logic                  apb_en,
    input  logic                  apb_write,
    input  logic [ADDR_W-1:0]     apb_addr,
    input  logic [DATA_W-1:0]     apb_wdata,
    output logic [DATA_W-1:0]     apb_rdata,
    output logic                  apb_ready,
    output logic                  apb_slverr,
    output logic [PROT_CNT_W-1:0] prot_err_cnt
);

    localparam int unsigned WAIT_IDX = NUM_REGS - WAIT_CFG_OFFSET;
    localparam int unsigned ID_IDX   = NUM_REGS - ID_OFFSET;
    localparam int unsigned GP_REGS  = NUM_REGS - 2;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   cap_addr;
    logic                cap_write;
    logic [DATA_W-1:0]   cap_wdata;
    logic [WAIT_W-1:0]   wait_cfg;
    logic [DATA_W-1:0]   regs [GP_REGS];
    logic [DATA_W-1:0]   rd_val;
    logic                wait_load, wait_dec, wait_zero;
    logic                ready_c, addr_err, commit;

    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) state <= IDLE;
        else            state <= state_next;
    end

    // Transfer sequencing: setup capture, wait-state countdown, single-cycle ready
    always_comb begin
        state_next = state;
        wait_load  = 1'b0;
        wait_dec   = 1'b0;
        ready_c    = 1'b0;
        case (state)
            IDLE: begin
                if (apb_selx && !apb_en) begin
                    state_next = ACCESS;
                    wait_load  = 1'b1;
                end
            end
            ACCESS: begin
                if (!apb_selx) begin
                    state_next = IDLE;
                end else if (apb_en) begin
                    if (wait_zero) begin
                        ready_c    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        wait_dec = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    apb_wait_ctr u_wait_ctr (
        .apb_clk   (apb_clk),
        .sys_reset (sys_reset),
        .load      (wait_load),
        .load_val  (wait_cfg),
        .dec       (wait_dec),
        .zero_c    (wait_zero)
    );

    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else if (wait_load) begin
            cap_addr  <= apb_addr;
            cap_write <= apb_write;
            cap_wdata <= apb_wdata;
        end
    end

    assign addr_err = (32'(cap_addr) >= NUM_REGS) || (cap_write && 32'(cap_addr) == ID_IDX);
    assign commit   = ready_c && cap_write && !addr_err;

    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            for (int i = 0; i < GP_REGS; i++) regs[i] <= '0;
            wait_cfg <= WAIT_W'(WAIT_DEFAULT);
        end else if (commit) begin
            for (int i = 0; i < GP_REGS; i++) begin
                if (32'(cap_addr) == 32'(i)) regs[i] <= cap_wdata;
            end
            if (32'(cap_addr) == WAIT_IDX) wait_cfg <= cap_wdata[WAIT_W-1:0];
        end
    end

    always_comb begin
        rd_val = '0;
        if (32'(cap_addr) == ID_IDX) begin
            rd_val = ID_VALUE;
        end else if (32'(cap_addr) == WAIT_IDX) begin
            rd_val = DATA_W'(wait_cfg);
        end else begin
            for (int i = 0; i < GP_REGS; i++) begin
                if (32'(cap_addr) == 32'(i)) rd_val = regs[i];
            end
        end
    end

    assign apb_ready  = ready_c;
    assign apb_slverr = ready_c && addr_err;
    assign apb_rdata  = (ready_c && !addr_err) ? rd_val : '0;

`ifdef APB_PROT_ERR_CNT_EN
    logic                  violation_c;
    logic [PROT_CNT_W-1:0] err_cnt;

    // One count per cycle in which any protocol rule is broken
    always_comb begin
        violation_c = 1'b0;
        if (state == IDLE && apb_selx && apb_en) violation_c = 1'b1;
        if (state == ACCESS && !apb_selx) violation_c = 1'b1;
        if (state == ACCESS && apb_selx && (apb_write != cap_write || apb_addr != cap_addr))
            violation_c = 1'b1;
    end

    always_ff @(posedge apb_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            err_cnt <= '0;
        end else if (violation_c && err_cnt != '1) begin
            err_cnt <= err_cnt + PROT_CNT_W'(1);
        end
    end

    assign prot_err_cnt = err_cnt;
`else
    assign prot_err_cnt = '0;
`endif

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Self-checking bench for apb_regbank_slave: directed table, corner sequences, random ops vs model.
module tb_apb_regbank_slave;

    localparam logic [31:0] ID_VAL = 32'hA5B0_0001;

    logic        apb_clk = 1'b0;
    logic        sys_reset;
    logic        apb_selx, apb_en, apb_write;
    logic [7:0]  apb_addr;
    logic [31:0] apb_wdata, apb_rdata;
    logic        apb_ready, apb_slverr;
    logic [7:0]  prot_err_cnt;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // Reference model: plain register image plus the wait configuration
    logic [31:0] mem [32];
    logic [3:0]  mwait;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;
    vec_t tbl [10];

    apb_regbank_slave dut (
        .apb_clk      (apb_clk),
        .sys_reset    (sys_reset),
        .apb_selx     (apb_selx),
        .apb_en       (apb_en),
        .apb_write    (apb_write),
        .apb_addr     (apb_addr),
        .apb_wdata    (apb_wdata),
        .apb_rdata    (apb_rdata),
        .apb_ready    (apb_ready),
        .apb_slverr   (apb_slverr),
        .prot_err_cnt (prot_err_cnt)
    );

    always #5 apb_clk = ~apb_clk;
    always @(posedge apb_clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_exp(input logic wr, input logic [7:0] a,
                                      output logic [31:0] rd, output logic err);
        err = (a >= 8'd32) || (wr && a == 8'd31);
        if (err)            rd = 32'h0;
        else if (a == 8'd31) rd = ID_VAL;
        else if (a == 8'd30) rd = {28'h0, mwait};
        else                rd = mem[a[4:0]];
    endfunction

    function automatic void model_commit(input logic wr, input logic [7:0] a, input logic [31:0] wd);
        if (wr && a < 8'd31) begin
            if (a == 8'd30) mwait = wd[3:0];
            else            mem[a[4:0]] = wd;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mwait = 4'd0;
    endfunction

    // Starts and ends just after a rising edge; the next call may start a setup with no gap
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat, output int rcyc);
        apb_selx = 1'b1; apb_en = 1'b0; apb_write = wr; apb_addr = addr; apb_wdata = wd;
        @(posedge apb_clk); #1;
        apb_en = 1'b1;
        apb_wdata = $urandom;
        lat = 0; rd = '0; err = 1'b0; rcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge apb_clk);
            lat++;
            if (apb_ready) begin
                rd = apb_rdata; err = apb_slverr; rcyc = cyc;
                break;
            end
            @(posedge apb_clk); #1;
            apb_wdata = $urandom;
        end
        check("ready_seen", 32'(rcyc >= 0), 32'd1);
        @(posedge apb_clk); #1;
        apb_selx = 1'b0; apb_en = 1'b0;
    endtask

    task automatic model_op(input logic wr, input logic [7:0] a, input logic [31:0] wd, input string name);
        logic [31:0] erd, rd;
        logic        eerr, err;
        int          elat, lat, rc;
        model_exp(wr, a, erd, eerr);
        elat = int'(mwait) + 1;
        xfer(wr, a, wd, rd, err, lat, rc);
        check({name, "_err"}, 32'(err), 32'(eerr));
        if (!wr || eerr) check({name, "_rdata"}, rd, erd);
        check({name, "_lat"}, 32'(lat), 32'(elat));
        if (!eerr) model_commit(wr, a, wd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          rc [3];
        int          exp_prot;

        tbl[0] = '{1'b1, 8'd4,   32'h0000_000A, 32'h0,          1'b0, 1};
        tbl[1] = '{1'b0, 8'd4,   32'h0,         32'h0000_000A, 1'b0, 1};
        tbl[2] = '{1'b1, 8'd30,  32'h0000_0003, 32'h0,          1'b0, 1};
        tbl[3] = '{1'b0, 8'd5,   32'h0,         32'h0,          1'b0, 4};
        tbl[4] = '{1'b0, 8'd30,  32'h0,         32'h0000_0003, 1'b0, 4};
        tbl[5] = '{1'b0, 8'd100, 32'h0,         32'h0,          1'b1, 4};
        tbl[6] = '{1'b1, 8'd31,  32'h0000_0055, 32'h0,          1'b1, 4};
        tbl[7] = '{1'b0, 8'd31,  32'h0,         ID_VAL,         1'b0, 4};
        tbl[8] = '{1'b1, 8'd30,  32'hFFFF_FFF0, 32'h0,          1'b0, 4};
        tbl[9] = '{1'b0, 8'd30,  32'h0,         32'h0,          1'b0, 1};

        model_reset();
        exp_prot = 0;
        sys_reset = 1'b0; apb_selx = 1'b0; apb_en = 1'b0; apb_write = 1'b0;
        apb_addr = '0; apb_wdata = '0;
        repeat (3) @(posedge apb_clk);
        #1;
        check("rst_ready",  32'(apb_ready),  32'd0);
        check("rst_slverr", 32'(apb_slverr), 32'd0);
        check("rst_rdata",  apb_rdata,       32'd0);
        check("rst_prot",   32'(prot_err_cnt), 32'd0);
        sys_reset = 1'b1;
        @(posedge apb_clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, err, lat, rc[0]);
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
            if (!tbl[i].wr || tbl[i].err) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            if (!tbl[i].err) model_commit(tbl[i].wr, tbl[i].addr, tbl[i].wd);
        end

        // Abort by dropping select after one access cycle, WAIT_CFG=5
        model_op(1'b1, 8'd30, 32'd5, "set_wait5");
        apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b1; apb_addr = 8'd7; apb_wdata = 32'h77;
        @(posedge apb_clk); #1;
        apb_en = 1'b1;
        @(negedge apb_clk);
        check("abort_acc1_ready", 32'(apb_ready), 32'd0);
        @(posedge apb_clk); #1;
        apb_selx = 1'b0; apb_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge apb_clk);
            check("abort_idle_ready", 32'(apb_ready), 32'd0);
        end
        @(posedge apb_clk); #1;
        model_op(1'b0, 8'd7, 32'h0, "abort_rd7");
`ifdef APB_PROT_ERR_CNT_EN
        exp_prot = 1;
`endif
        check("abort_prot", 32'(prot_err_cnt), 32'(exp_prot));

        // Enable without a setup phase from idle
        apb_selx = 1'b1; apb_en = 1'b1; apb_addr = 8'd3; apb_write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge apb_clk);
            check("nosetup_ready", 32'(apb_ready), 32'd0);
            @(posedge apb_clk); #1;
        end
        apb_selx = 1'b0; apb_en = 1'b0;
`ifdef APB_PROT_ERR_CNT_EN
        exp_prot = 3;
`endif
        @(posedge apb_clk); #1;
        check("nosetup_prot", 32'(prot_err_cnt), 32'(exp_prot));

        // Back-to-back writes with zero wait states
        model_op(1'b1, 8'd30, 32'd0, "set_wait0");
        xfer(1'b1, 8'd1, 32'h1111_0001, rd, err, lat, rc[0]);
        xfer(1'b1, 8'd2, 32'h2222_0002, rd, err, lat, rc[1]);
        xfer(1'b1, 8'd3, 32'h3333_0003, rd, err, lat, rc[2]);
        check("b2b_gap1", 32'(rc[1] - rc[0]), 32'd2);
        check("b2b_gap2", 32'(rc[2] - rc[1]), 32'd2);
        model_commit(1'b1, 8'd1, 32'h1111_0001);
        model_commit(1'b1, 8'd2, 32'h2222_0002);
        model_commit(1'b1, 8'd3, 32'h3333_0003);
        model_op(1'b0, 8'd1, 32'h0, "b2b_rd1");
        model_op(1'b0, 8'd2, 32'h0, "b2b_rd2");
        model_op(1'b0, 8'd3, 32'h0, "b2b_rd3");

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            logic [7:0]  a;
            logic        w;
            logic [31:0] d;
            a = 8'($urandom_range(0, 35));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            model_op(w, a, d, $sformatf("rnd%0d", i));
        end
        check("rnd_prot", 32'(prot_err_cnt), 32'(exp_prot));

        // Reset during the ready cycle of a write aborts its commit
        model_op(1'b1, 8'd30, 32'd0, "rst_wait0");
        model_op(1'b1, 8'd2, 32'h12, "rst_wr2");
        apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b1; apb_addr = 8'd9; apb_wdata = 32'h99;
        @(posedge apb_clk); #1;
        apb_en = 1'b1;
        #1;
        check("midrst_ready_before", 32'(apb_ready), 32'd1);
        sys_reset = 1'b0;
        #1;
        check("midrst_ready",  32'(apb_ready),  32'd0);
        check("midrst_slverr", 32'(apb_slverr), 32'd0);
        check("midrst_rdata",  apb_rdata,       32'd0);
        @(posedge apb_clk); #1;
        apb_selx = 1'b0; apb_en = 1'b0;
        @(posedge apb_clk); #1;
        sys_reset = 1'b1;
        model_reset();
        @(posedge apb_clk); #1;
        check("midrst_prot", 32'(prot_err_cnt), 32'd0);
        model_op(1'b0, 8'd2,  32'h0, "midrst_rd2");
        model_op(1'b0, 8'd9,  32'h0, "midrst_rd9");
        model_op(1'b0, 8'd30, 32'h0, "midrst_rdwait");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
- APB completer (responder) holding a word-indexed register bank, driven by the apb_master initiator on the shared APB bus.
- Programmable wait states, up to 15 cycles, which stays below the master's 20-cycle timeout.
- PSLVERR-style error response for out-of-range accesses and writes to read-only registers.
- Counts protocol violations, for use in bring-up and verification.

Parameters:
- NUM_REGS, 32: number of word registers; addr indexes words 0..NUM_REGS-1.
- ID_VALUE, 32'hA5B0_0001: constant returned by the ID register at index NUM_REGS-1.
- WAIT_DEFAULT, 0: reset value of the WAIT_CFG register, range 0-15.

Ports:
- apb_clk  in  1  clock.
- sys_reset  in  1  reset: asynchronous, active-low.
- apb_selx  in  1  slave select.
- apb_en  in  1  access-phase enable.
- apb_write  in  1  1 = write, 0 = read.
- apb_addr  in  8  word index.
- apb_wdata  in  32  write data.
- apb_rdata  out  32  read data; valid only while apb_ready=1.
- apb_ready  out  1  transfer completes in this cycle.
- apb_slverr  out  1  error response; valid only while apb_ready=1.
- prot_err_cnt  out  8  saturating protocol-violation count; tied to 0 unless the macro is defined.

Behaviour:
- Reset (sys_reset=0, async):
  - state=IDLE; apb_ready=0, apb_slverr=0, apb_rdata=0.
  - Registers 0..NUM_REGS-3 = 0; WAIT_CFG=WAIT_DEFAULT; prot_err_cnt=0.
  - Reset asserted mid-transfer aborts the transfer with no write commit.
- Register map:
  - Index 0..NUM_REGS-3: general RW.
  - Index NUM_REGS-2 = WAIT_CFG: RW bits [3:0]; bits [31:4] read 0 and ignore writes.
  - Index NUM_REGS-1 = ID: read-only, returns ID_VALUE.
- FSM states: IDLE, ACCESS.
  - IDLE: on apb_selx=1 & apb_en=0 (setup phase), capture addr/write/wdata, load wait_cnt=WAIT_CFG[3:0], go to ACCESS.
  - IDLE: apb_selx=1 & apb_en=1 without a preceding setup is a violation; stay in IDLE, no ready.
  - ACCESS: if apb_selx=0, abort (violation), return to IDLE, no commit.
  - ACCESS: if apb_en=1 & wait_cnt!=0, decrement wait_cnt and keep ready=0.
  - ACCESS: if apb_en=1 & wait_cnt==0, assert apb_ready for exactly one cycle, then go to IDLE.
  - ACCESS: if apb_en=0 while selected, hold state; wait_cnt does not decrement.
- Latency: a zero-wait transfer is 2 cycles (setup + access). With WAIT_CFG=N, ready is asserted on access cycle N+1.
- Ready, rdata and slverr are combinational from registered state plus captured address.
- The write commits on the rising edge that ends the ready cycle. Addr/data changes by the master after setup are ignored; captured values are used.
- Error rules: captured addr >= NUM_REGS, or a write to ID, gives slverr=1 and rdata=0, with no state change.
- A write to WAIT_CFG takes effect from the next transfer.
- Back-to-back: a setup phase seen in the cycle after ready starts a new transfer with no idle gap required.

Optional Feature:
- Macro: APB_PROT_ERR_CNT_EN.
- When defined: prot_err_cnt increments, saturating at 255, on each violation:
  - en without setup;
  - selx dropped mid-ACCESS;
  - apb_write or captured address changing during ACCESS (compared against the setup-phase capture).
  - It clears only on reset.
- When not defined: prot_err_cnt=0 constant; violations are still handled as above, with no comparison logic.

Decomposition:
- Package apb_pkg holds:
  - state enum (IDLE, ACCESS);
  - localparams for the WAIT_CFG/ID index offsets, WAIT_CFG field width (4) and prot_err_cnt width (8);
  - the ID_VALUE default.
- One natural sub-module, apb_wait_ctr: loadable 4-bit down-counter with a zero flag. The register array stays inline.

Test Plan:
- Reset, then write 32'h0000_000A to idx 4, then read idx 4 (WAIT_CFG=0): each transfer is 2 cycles; ready high on cycle 2; rdata=0x0A; slverr=0.
- Write 3 to idx 30 (WAIT_CFG), then read idx 5: ready rises on the 4th access cycle; reading idx 30 returns 0x3.
- Read idx 100; then write 0x55 to idx 31: slverr=1 with ready on both; the read returns rdata=0; a subsequent read of idx 31 returns 32'hA5B0_0001.
- Drop apb_selx after 1 access cycle with WAIT_CFG=5 during a write of 0x77 to idx 7: no ready pulse; idx 7 still reads 0. With APB_PROT_ERR_CNT_EN, prot_err_cnt=1.
- Assert sys_reset low mid-ACCESS after writing 0x12 to idx 2: ready/slverr drop immediately (async); idx 2 reads 0; WAIT_CFG reads WAIT_DEFAULT.
- Back-to-back writes to idx 1, 2, 3 with no idle cycles: three ready pulses, one every 2 cycles; all three values read back correctly.
